// File: rtl/xmega_fetch.sv
// rtl/xmega_fetch.sv - instruction fetch/prefetch stage with 3-word queue, 32-bit assembly, redirect and skip
module xmega_fetch #(
    parameter int unsigned                PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]        RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] pmem_addr,
    output logic                pmem_rd,
    input  logic [15:0]         pmem_data,
    output logic [15:0]         inst_out,
    output logic [15:0]         inst_ext,
    output logic [PC_WIDTH-1:0] inst_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                skip
);

    logic [15:0]         qw_q [3];
    logic [15:0]         qw_d [3];
    logic [PC_WIDTH-1:0] qa_q [3];
    logic [PC_WIDTH-1:0] qa_d [3];
    logic [1:0]          cnt_q, cnt_d;
    logic                infl_q, infl_d;
    logic [PC_WIDTH-1:0] infl_addr_q, infl_addr_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                skip_pend_q, skip_pend_d;

    logic       head_is32;
    logic       head_complete;
    logic       room;
    logic       hs;
    logic       drop;
    logic       push;
    logic [1:0] pop_n;
    logic [1:0] cnt_after;

    function automatic logic is_32bit(input logic [15:0] w);
        return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
    endfunction

    // Occupancy is the registered count only; a same-cycle pop does not free a slot for issue.
    assign head_is32     = is_32bit(qw_q[0]);
    assign head_complete = head_is32 ? (cnt_q >= 2'd2) : (cnt_q != 2'd0);
    assign room          = ({1'b0, cnt_q} + {2'b00, infl_q}) < 3'd3;

    assign pmem_rd    = rst_n & (redirect | room);
    assign pmem_addr  = (redirect && rst_n) ? redirect_pc : fetch_pc_q;
    assign inst_valid = head_complete & ~skip_pend_q & ~redirect;
    assign inst_out   = qw_q[0];
    assign inst_ext   = head_is32 ? qw_q[1] : 16'h0000;
    assign inst_pc    = qa_q[0];

    assign hs   = inst_valid & inst_ready;
    assign drop = skip_pend_q & head_complete & ~redirect;
    assign push = infl_q & ~redirect;

    always_comb begin
        qw_d        = qw_q;
        qa_d        = qa_q;
        cnt_d       = cnt_q;
        infl_d      = 1'b0;
        infl_addr_d = infl_addr_q;
        fetch_pc_d  = fetch_pc_q;
        skip_pend_d = skip_pend_q;
        pop_n       = 2'd0;
        cnt_after   = cnt_q;

        if (redirect) begin
            cnt_d       = 2'd0;
            skip_pend_d = 1'b0;
            infl_d      = 1'b1;
            infl_addr_d = redirect_pc;
            fetch_pc_d  = redirect_pc + PC_WIDTH'(1);
        end else begin
            if (hs || drop) begin
                pop_n = head_is32 ? 2'd2 : 2'd1;
            end
            case (pop_n)
                2'd1: begin
                    qw_d[0] = qw_q[1];
                    qa_d[0] = qa_q[1];
                    qw_d[1] = qw_q[2];
                    qa_d[1] = qa_q[2];
                end
                2'd2: begin
                    qw_d[0] = qw_q[2];
                    qa_d[0] = qa_q[2];
                end
                default: ;
            endcase
            cnt_after = cnt_q - pop_n;
            // Issue-time credit check guarantees cnt_after <= 2 whenever a response lands.
            if (push) begin
                case (cnt_after)
                    2'd0: begin
                        qw_d[0] = pmem_data;
                        qa_d[0] = infl_addr_q;
                    end
                    2'd1: begin
                        qw_d[1] = pmem_data;
                        qa_d[1] = infl_addr_q;
                    end
                    default: begin
                        qw_d[2] = pmem_data;
                        qa_d[2] = infl_addr_q;
                    end
                endcase
            end
            cnt_d = cnt_after + {1'b0, push};
            if (room) begin
                infl_d      = 1'b1;
                infl_addr_d = fetch_pc_q;
                fetch_pc_d  = fetch_pc_q + PC_WIDTH'(1);
            end
            skip_pend_d = skip | (skip_pend_q & ~drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                qw_q[i] <= 16'h0000;
                qa_q[i] <= RESET_VECTOR;
            end
            cnt_q       <= 2'd0;
            infl_q      <= 1'b0;
            infl_addr_q <= RESET_VECTOR;
            fetch_pc_q  <= RESET_VECTOR;
            skip_pend_q <= 1'b0;
        end else begin
            qw_q        <= qw_d;
            qa_q        <= qa_d;
            cnt_q       <= cnt_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            skip_pend_q <= skip_pend_d;
        end
    end

endmodule
